// File: rtl/axi_pkg.sv
// Shared AXI definitions for the driver/memory boundary slices.
// Holds RRESP encodings and default-width beat/tracking records.
package axi_pkg;

    localparam int AXI_PKG_DATA_W = 64;
    localparam int AXI_PKG_ID_W   = 4;
    localparam int AR_LEN_W       = 8;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_PKG_DATA_W-1:0] data;
        logic [AXI_PKG_ID_W-1:0]   id;
        logic [1:0]                resp;
        logic                      last;
    } r_beat_t;

    typedef struct packed {
        logic [AXI_PKG_ID_W-1:0] id;
        logic [AR_LEN_W-1:0]     len;
    } ar_track_t;

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry skid buffer with a generic payload; ready is taken from the
// registered occupancy only, so it never combinationally follows i_ready.
module axi_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    // NOTE: non-blocking everywhere here so pointer, count and entry
    // updates all act on the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axi_r_return.sv
// R return path: in-order AR tracking, RLAST regeneration from AXLEN,
// protocol error pulses, and a 2-entry skid buffer towards the driver.
module axi_r_return
    import axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ar_push,
    input  logic [AXI_ID_WIDTH-1:0]              ar_id,
    input  logic [AR_LEN_W-1:0]                  ar_len,
    output logic                                 ar_allow,
    input  logic [AXI_DATA_WIDTH-1:0]            mr_rdata,
    input  logic [AXI_ID_WIDTH-1:0]              mr_rid,
    input  logic [1:0]                           mr_rresp,
    input  logic                                 mr_rlast,
    input  logic                                 mr_rvalid,
    output logic                                 mr_rready,
    output logic [AXI_DATA_WIDTH-1:0]            dr_rdata,
    output logic [AXI_ID_WIDTH-1:0]              dr_rid,
    output logic [1:0]                           dr_rresp,
    output logic                                 dr_rlast,
    output logic                                 dr_rvalid,
    input  logic                                 dr_rready,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err_id,
    output logic                                 err_last_early,
    output logic                                 err_last_missing,
    output logic                                 err_no_req,
    output logic                                 err_ar_overflow
);

    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = AXI_DATA_WIDTH + AXI_ID_WIDTH + 3;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [AR_LEN_W-1:0]     len;
    } track_t;

    track_t              r_ar_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    r_ar_wr_ptr;
    logic [PTR_W-1:0]    r_ar_rd_ptr;
    logic [CNT_W-1:0]    r_ar_count;
    logic [AR_LEN_W-1:0] r_beat_cnt;

    track_t              w_head;
    logic                w_ar_empty;
    logic                w_ar_push;
    logic                w_ar_pop;
    logic                w_mr_hs;
    logic                w_beat_ok;
    logic                w_is_last;
    logic [BEAT_W-1:0]   w_skid_in;
    logic [BEAT_W-1:0]   w_skid_out;

    assign w_head      = r_ar_mem[r_ar_rd_ptr];
    assign w_ar_empty  = (r_ar_count == '0);
    assign ar_allow    = (r_ar_count != CNT_W'(MAX_OUTSTANDING));
    assign outstanding = r_ar_count;
    assign w_ar_push   = ar_push & ar_allow;

    assign w_mr_hs   = mr_rvalid & mr_rready;
    assign w_beat_ok = w_mr_hs & ~w_ar_empty;
    assign w_is_last = (r_beat_cnt == w_head.len);
    assign w_ar_pop  = w_beat_ok & w_is_last;

    // NOTE: tracking storage is not reset; r_ar_count guards every read,
    // so only pointers and count need clearing.
    always_ff @(posedge clk) begin
        if (w_ar_push) begin
            r_ar_mem[r_ar_wr_ptr] <= {ar_id, ar_len};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar_wr_ptr <= '0;
            r_ar_rd_ptr <= '0;
            r_ar_count  <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_ar_push) begin
                r_ar_wr_ptr <= r_ar_wr_ptr + PTR_W'(1);
            end
            if (w_ar_pop) begin
                r_ar_rd_ptr <= r_ar_rd_ptr + PTR_W'(1);
            end
            case ({w_ar_push, w_ar_pop})
                2'b10:   r_ar_count <= r_ar_count + CNT_W'(1);
                2'b01:   r_ar_count <= r_ar_count - CNT_W'(1);
                default: r_ar_count <= r_ar_count;
            endcase
            if (w_beat_ok) begin
                r_beat_cnt <= w_is_last ? '0 : r_beat_cnt + AR_LEN_W'(1);
            end
        end
    end

    // Error pulses land one cycle after the offending handshake or push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_id           <= 1'b0;
            err_last_early   <= 1'b0;
            err_last_missing <= 1'b0;
            err_no_req       <= 1'b0;
            err_ar_overflow  <= 1'b0;
        end else begin
            err_id           <= w_beat_ok & (mr_rid != w_head.id);
            err_last_early   <= w_beat_ok & mr_rlast & (r_beat_cnt < w_head.len);
            err_last_missing <= w_beat_ok & w_is_last & ~mr_rlast;
            err_no_req       <= w_mr_hs & w_ar_empty;
            err_ar_overflow  <= ar_push & ~ar_allow;
        end
    end

    // Forward with the tracked ID and regenerated RLAST; RRESP passes through.
    assign w_skid_in = {mr_rdata, w_head.id, mr_rresp, w_is_last};

    axi_skid_buffer #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_beat_ok),
        .o_ready (mr_rready),
        .i_data  (w_skid_in),
        .o_valid (dr_rvalid),
        .i_ready (dr_rready),
        .o_data  (w_skid_out)
    );

    assign {dr_rdata, dr_rid, dr_rresp, dr_rlast} = w_skid_out;

endmodule

// File: tb/tb_axi_r_return.sv
// Self-checking bench for axi_r_return: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_axi_r_return;
    import axi_pkg::*;

    localparam int DW   = 64;
    localparam int IW   = 4;
    localparam int MAXO = 4;
    localparam int OW   = $clog2(MAXO) + 1;

    logic          clk;
    logic          rst_n;
    logic          ar_push;
    logic [IW-1:0] ar_id;
    logic [7:0]    ar_len;
    logic          ar_allow;
    logic [DW-1:0] mr_rdata;
    logic [IW-1:0] mr_rid;
    logic [1:0]    mr_rresp;
    logic          mr_rlast;
    logic          mr_rvalid;
    logic          mr_rready;
    logic [DW-1:0] dr_rdata;
    logic [IW-1:0] dr_rid;
    logic [1:0]    dr_rresp;
    logic          dr_rlast;
    logic          dr_rvalid;
    logic          dr_rready;
    logic [OW-1:0] outstanding;
    logic          err_id;
    logic          err_last_early;
    logic          err_last_missing;
    logic          err_no_req;
    logic          err_ar_overflow;

    axi_r_return #(
        .AXI_DATA_WIDTH  (DW),
        .AXI_ID_WIDTH    (IW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ar_push          (ar_push),
        .ar_id            (ar_id),
        .ar_len           (ar_len),
        .ar_allow         (ar_allow),
        .mr_rdata         (mr_rdata),
        .mr_rid           (mr_rid),
        .mr_rresp         (mr_rresp),
        .mr_rlast         (mr_rlast),
        .mr_rvalid        (mr_rvalid),
        .mr_rready        (mr_rready),
        .dr_rdata         (dr_rdata),
        .dr_rid           (dr_rid),
        .dr_rresp         (dr_rresp),
        .dr_rlast         (dr_rlast),
        .dr_rvalid        (dr_rvalid),
        .dr_rready        (dr_rready),
        .outstanding      (outstanding),
        .err_id           (err_id),
        .err_last_early   (err_last_early),
        .err_last_missing (err_last_missing),
        .err_no_req       (err_no_req),
        .err_ar_overflow  (err_ar_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending bursts, beat index in head burst, beats held
    // between the two sides.
    ar_track_t ar_q[$];
    r_beat_t   sb[$];
    int        beat_no  = 0;
    int        n_popped = 0;

    typedef struct packed {
        logic          ar_push;
        logic [IW-1:0] ar_id;
        logic [7:0]    ar_len;
        logic          mr_valid;
        logic [IW-1:0] rid;
        logic          rlast;
        logic          e_dvalid;
        logic          e_dlast;
        logic [IW-1:0] e_did;
        logic [4:0]    e_err;
        logic [OW-1:0] e_out;
    } vec_t;

    function automatic vec_t v(input logic p, input int id, input int len,
                               input logic mv, input int rid, input logic rl,
                               input logic dv, input logic dl, input int did,
                               input logic [4:0] er, input int outs);
        vec_t r;
        r.ar_push  = p;
        r.ar_id    = IW'(id);
        r.ar_len   = 8'(len);
        r.mr_valid = mv;
        r.rid      = IW'(rid);
        r.rlast    = rl;
        r.e_dvalid = dv;
        r.e_dlast  = dl;
        r.e_did    = IW'(did);
        r.e_err    = er;
        r.e_out    = OW'(outs);
        return r;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] err_vec();
        return {err_id, err_last_early, err_last_missing, err_no_req, err_ar_overflow};
    endfunction

    task automatic model_reset();
        ar_q.delete();
        sb.delete();
        beat_no = 0;
    endtask

    // Advance the model across one clock edge, then compare after the edge.
    task automatic cycle();
        logic [4:0] e_err;
        bit         pre_allow;
        bit         pop_d;
        bit         hs;
        bit         last;
        ar_track_t  head;
        e_err     = '0;
        pre_allow = (ar_q.size() < MAXO);
        pop_d     = (sb.size() > 0) && dr_rready;
        hs        = mr_rvalid && (sb.size() < 2);
        if (pop_d) begin
            sb.delete(0);
            n_popped++;
        end
        if (hs) begin
            if (ar_q.size() == 0) begin
                e_err[1] = 1'b1;
            end else begin
                head     = ar_q[0];
                last     = (beat_no == int'(head.len));
                e_err[4] = (mr_rid != head.id);
                e_err[3] = mr_rlast && (beat_no < int'(head.len));
                e_err[2] = last && !mr_rlast;
                sb.push_back('{data: mr_rdata, id: head.id, resp: mr_rresp, last: last});
                if (last) begin
                    ar_q.delete(0);
                    beat_no = 0;
                end else begin
                    beat_no++;
                end
            end
        end
        if (ar_push) begin
            if (pre_allow) ar_q.push_back('{id: ar_id, len: ar_len});
            else           e_err[0] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("dr_rvalid", 80'(dr_rvalid), 80'(sb.size() > 0));
        check("mr_rready", 80'(mr_rready), 80'(sb.size() < 2));
        check("ar_allow", 80'(ar_allow), 80'(ar_q.size() < MAXO));
        check("outstanding", 80'(outstanding), 80'(ar_q.size()));
        check("err_pulses", 80'(err_vec()), 80'(e_err));
        if (sb.size() > 0)
            check("dr_beat", 80'({dr_rdata, dr_rid, dr_rresp, dr_rlast}), 80'(sb[0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        int   popped_start;
        int   sent;

        vecs[0]  = v(1, 3, 3, 0, 0, 0, 0, 0, 0, 5'b00000, 1);
        vecs[1]  = v(0, 0, 0, 1, 3, 0, 1, 0, 3, 5'b00000, 1);
        vecs[2]  = v(0, 0, 0, 1, 3, 0, 1, 0, 3, 5'b00000, 1);
        vecs[3]  = v(0, 0, 0, 1, 3, 0, 1, 0, 3, 5'b00000, 1);
        vecs[4]  = v(0, 0, 0, 1, 3, 1, 1, 1, 3, 5'b00000, 0);
        vecs[5]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0);
        vecs[6]  = v(1, 1, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 1);
        vecs[7]  = v(0, 0, 0, 1, 1, 1, 1, 0, 1, 5'b01000, 1);
        vecs[8]  = v(0, 0, 0, 1, 1, 1, 1, 1, 1, 5'b00000, 0);
        vecs[9]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1);
        vecs[10] = v(0, 0, 0, 1, 0, 0, 1, 1, 0, 5'b00100, 0);
        vecs[11] = v(1, 2, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1);
        vecs[12] = v(0, 0, 0, 1, 5, 1, 1, 1, 2, 5'b10000, 0);
        vecs[13] = v(0, 0, 0, 1, 7, 1, 0, 0, 0, 5'b00010, 0);
        vecs[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0);

        rst_n     = 1'b0;
        ar_push   = 1'b0;
        ar_id     = '0;
        ar_len    = '0;
        mr_rvalid = 1'b0;
        mr_rdata  = '0;
        mr_rid    = '0;
        mr_rresp  = RRESP_OKAY;
        mr_rlast  = 1'b0;
        dr_rready = 1'b1;
        #12;
        check("rst_dr_rvalid", 80'(dr_rvalid), 80'(0));
        check("rst_dr_payload", 80'({dr_rdata, dr_rid, dr_rresp, dr_rlast}), 80'(0));
        check("rst_ar_allow", 80'(ar_allow), 80'(1));
        check("rst_mr_rready", 80'(mr_rready), 80'(1));
        check("rst_outstanding", 80'(outstanding), 80'(0));
        check("rst_err", 80'(err_vec()), 80'(0));
        #1 rst_n = 1'b1;

        // Directed vectors: single burst, early/missing RLAST, ID mismatch, no request.
        for (int i = 0; i < 15; i++) begin
            ar_push   = vecs[i].ar_push;
            ar_id     = vecs[i].ar_id;
            ar_len    = vecs[i].ar_len;
            mr_rvalid = vecs[i].mr_valid;
            mr_rid    = vecs[i].rid;
            mr_rlast  = vecs[i].rlast;
            mr_rdata  = {32'hA5A5_0000, 32'(i)};
            mr_rresp  = (i % 2 == 0) ? RRESP_EXOKAY : RRESP_SLVERR;
            cycle();
            check($sformatf("vec%0d_dvalid", i), 80'(dr_rvalid), 80'(vecs[i].e_dvalid));
            if (vecs[i].e_dvalid) begin
                check($sformatf("vec%0d_dlast", i), 80'(dr_rlast), 80'(vecs[i].e_dlast));
                check($sformatf("vec%0d_did", i), 80'(dr_rid), 80'(vecs[i].e_did));
            end
            check($sformatf("vec%0d_err", i), 80'(err_vec()), 80'(vecs[i].e_err));
            check($sformatf("vec%0d_out", i), 80'(outstanding), 80'(vecs[i].e_out));
        end
        ar_push   = 1'b0;
        mr_rvalid = 1'b0;

        // Fill the tracker, overflow alone, then overflow alongside a pop.
        for (int i = 0; i < 4; i++) begin
            ar_push = 1'b1;
            ar_id   = IW'(i);
            ar_len  = 8'd0;
            cycle();
        end
        check("fill_ar_allow", 80'(ar_allow), 80'(0));
        ar_id = IW'(9);
        cycle();
        check("ovf_pulse", 80'(err_ar_overflow), 80'(1));
        check("ovf_outstanding", 80'(outstanding), 80'(4));
        ar_push = 1'b0;
        cycle();
        check("ovf_single_pulse", 80'(err_ar_overflow), 80'(0));
        ar_push   = 1'b1;
        ar_id     = IW'(10);
        mr_rvalid = 1'b1;
        mr_rid    = IW'(0);
        mr_rlast  = 1'b1;
        cycle();
        check("ovf_with_pop", 80'(err_ar_overflow), 80'(1));
        check("ovf_with_pop_out", 80'(outstanding), 80'(3));
        ar_push = 1'b0;
        for (int i = 1; i < 4; i++) begin
            mr_rid = IW'(i);
            cycle();
        end
        check("drain_outstanding", 80'(outstanding), 80'(0));
        mr_rid = IW'(9);
        cycle();
        check("dropped_ar_no_req", 80'(err_no_req), 80'(1));
        mr_rvalid = 1'b0;
        cycle();

        // 8-beat burst with dr_rready toggling 1010...
        ar_push = 1'b1;
        ar_id   = IW'(6);
        ar_len  = 8'd7;
        cycle();
        ar_push      = 1'b0;
        popped_start = n_popped;
        sent         = 0;
        for (int c = 0; c < 40 && (n_popped - popped_start) < 8; c++) begin
            dr_rready = (c % 2 == 0);
            mr_rvalid = (sent < 8);
            mr_rid    = IW'(6);
            mr_rlast  = (sent == 7);
            mr_rdata  = {$urandom, $urandom};
            if (mr_rvalid && mr_rready) sent++;
            cycle();
        end
        mr_rvalid = 1'b0;
        dr_rready = 1'b1;
        check("bp_beats_delivered", 80'(n_popped - popped_start), 80'(8));
        check("bp_outstanding", 80'(outstanding), 80'(0));

        // Asynchronous reset in the middle of a burst.
        ar_push   = 1'b1;
        ar_id     = IW'(4);
        ar_len    = 8'd3;
        dr_rready = 1'b0;
        cycle();
        ar_push   = 1'b0;
        mr_rvalid = 1'b1;
        mr_rid    = IW'(4);
        mr_rlast  = 1'b0;
        cycle();
        cycle();
        mr_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dr_rvalid", 80'(dr_rvalid), 80'(0));
        check("midrst_outstanding", 80'(outstanding), 80'(0));
        check("midrst_mr_rready", 80'(mr_rready), 80'(1));
        model_reset();
        #2 rst_n = 1'b1;
        dr_rready = 1'b1;
        mr_rvalid = 1'b1;
        cycle();
        check("postrst_no_req", 80'(err_no_req), 80'(1));
        mr_rvalid = 1'b0;
        cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            ar_push   = ($urandom_range(3) == 0);
            ar_id     = IW'($urandom);
            ar_len    = 8'($urandom_range(3));
            mr_rvalid = ($urandom_range(3) != 0);
            mr_rdata  = {$urandom, $urandom};
            mr_rresp  = 2'($urandom);
            if (ar_q.size() > 0 && $urandom_range(15) != 0) begin
                mr_rid   = ar_q[0].id;
                mr_rlast = (beat_no == int'(ar_q[0].len));
            end else begin
                mr_rid   = IW'($urandom);
                mr_rlast = 1'($urandom);
            end
            if ($urandom_range(15) == 0) mr_rlast = ~mr_rlast;
            dr_rready = ($urandom_range(3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_r_return.md
# axi_r_return

Read-data return path on the driver/memory boundary, the counterpart of the write-data forwarding slice. Accepts R beats from the memory side, buffers them in a 2-entry skid buffer and forwards them to the driver side. Tracks outstanding AR bursts in order, regenerates RLAST from the requested length and flags protocol violations.

## Interface
Parameters:
- AXI_DATA_WIDTH, 64, R data width
- AXI_ID_WIDTH, 4, ID width
- MAX_OUTSTANDING, 4, depth of the AR tracking FIFO (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ar_push  in  1  AR handshake occurred on the memory side this cycle
- ar_id  in  AXI_ID_WIDTH  ID of pushed AR
- ar_len  in  8  AXLEN of pushed AR (beats-1)
- ar_allow  out  1  tracking FIFO not full; AR issuer must gate AR on this
- mr_rdata / mr_rid / mr_rresp / mr_rlast  in  DATA / ID / 2 / 1  memory-side R payload
- mr_rvalid  in  1 ;  mr_rready  out  1
- dr_rdata / dr_rid / dr_rresp / dr_rlast  out  DATA / ID / 2 / 1  driver-side R payload
- dr_rvalid  out  1 ;  dr_rready  in  1
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  bursts tracked
- err_id, err_last_early, err_last_missing, err_no_req, err_ar_overflow  out  1 each  single-cycle error pulses

## Operation
- Reset: all FIFOs empty, beat counter 0, dr_rvalid 0, dr_* payload 0, ar_allow 1, mr_rready 1, outstanding 0, all err_* 0.
- AR tracking: ar_push with ar_allow=1 writes {ar_id, ar_len}. ar_push with ar_allow=0 is dropped and pulses err_ar_overflow, even when a pop occurs in the same cycle. A push and a pop in the same cycle when not full leaves outstanding unchanged.
- Responses are returned in AR order. Interleaving is not supported.
- On each mr beat handshake with the FIFO non-empty:
  - The beat is pushed to the skid buffer with dr_rlast = (beat_cnt == head.len).
  - If mr_rid != head.id, err_id pulses. The beat is forwarded with head.id.
  - If mr_rlast=1 and beat_cnt < head.len, err_last_early pulses and the burst continues.
  - If beat_cnt == head.len and mr_rlast=0, err_last_missing pulses.
  - When beat_cnt == head.len, the head is popped and beat_cnt resets to 0. Otherwise beat_cnt increments (8-bit, no wrap since it is bounded by len).
- Beat handshake with the FIFO empty: the beat is accepted and discarded, and err_no_req pulses.
- RRESP passes through unmodified. No SLVERR is injected.
- Skid buffer: 2 entries.
  - mr_rready = (skid_count < 2), combinational from registered count only.
  - dr_* is driven from the head entry.
  - Simultaneous push and pop keeps the count.

## Timing
- Latency: an mr handshake at cycle N makes the beat visible on dr_* at N+1 when the buffer was empty.
- Throughput: 1 beat/cycle sustained while dr_rready=1.
- Backpressure: dr_rready low for 2 cycles fills the buffer. mr_rready falls the cycle after the second fill and returns 1 the cycle after a dr pop.
- dr_rvalid/payload stay stable until dr_rready. dr_rvalid never depends combinationally on dr_rready.
- err_* pulse for exactly one cycle, at N+1 after the offending handshake or push.
- ar_allow and outstanding update at the cycle after push/pop.
- Async reset mid-burst: all state clears immediately and in-flight beats are lost. After release, the first beat without a new AR raises err_no_req.

## Structure
- Shared package axi_pkg holds:
  - RRESP constants OKAY/EXOKAY/SLVERR/DECERR
  - typedef r_beat_t {data, id, resp, last}, parameterised via package-level width localparams
  - typedef ar_track_t {id, len}
- Sub-module axi_skid_buffer (2-entry, generic payload width), reusable for the W path.
- The AR tracking FIFO and beat counter are inline.

## Test plan
- Reset, then one AR (id=3, len=3) and 4 beats with rlast on beat 4 → 4 dr beats at N+1 each, dr_rlast only on the 4th, outstanding 1→0, no errors.
- 4 ARs pushed (fill), then a 5th push → ar_allow=0 after the 4th, err_ar_overflow pulses once, outstanding=4. The 5th AR's beats later raise err_no_req.
- Burst len=1 with mr_rlast on beat 1 → err_last_early at beat 1, dr_rlast on beat 2. Burst len=0 with mr_rlast=0 → err_last_missing, dr_rlast=1.
- Beat with mr_rid=5 against head id=2 → err_id pulse, dr_rid=2.
- dr_rready toggled 1010… during an 8-beat burst → no lost or duplicated beats, data order preserved, mr_rready low only when 2 entries are held.
- rst_n asserted mid-burst (beat 2 of 4) → dr_rvalid=0 and outstanding=0 immediately. A following beat with no AR raises err_no_req.
